// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC-driven memory read, prefetch FIFO, decode handshake.
// Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memWriteEnable,
  input  logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPC,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPC,
  input  logic              halt
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stallCount
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  state_e state_q;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] word_q [DEPTH];
  logic [ADDR_W-1:0] wpc_q  [DEPTH];

  logic full;
  logic pop;
  logic run_ok;
  logic fetch;
  logic flush;

  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign pop    = instrValid & instrReady;
  assign run_ok = (state_q == RUN) & ~halt & ~redirect;
  assign fetch  = run_ok & (~full | pop);
  // Redirect is ignored during the post-reset idle cycle.
  assign flush  = redirect & (state_q != IDLE);

  assign memAddress     = pc_q;
  assign memWriteEnable = 1'b0;
  assign instrValid     = (cnt_q != '0);
  assign instr          = word_q[rd_q];
  assign instrPC        = wpc_q[rd_q];

  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      pc_d  = redirectPC;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (fetch) begin
        pc_d = pc_q + ADDR_W'(1);
        wr_d = wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      if (fetch && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !fetch) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fetch) begin
      word_q[wr_q] <= memDataOut;
      wpc_q[wr_q]  <= pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_q <= halt ? HALTED : RUN;
        RUN:     state_q <= halt ? HALTED : RUN;
        HALTED:  state_q <= (halt || redirect) ? HALTED : RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic        stall;
  logic [15:0] stall_q;

  assign stall      = run_ok & ~fetch;
  assign stallCount = stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] memAddress;
  logic        memWriteEnable;
  logic [15:0] memDataOut;
  logic [15:0] instr;
  logic [15:0] instrPC;
  logic        instrValid;
  logic        rdy = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] rpc = 16'h0000;
  logic        halt = 1'b0;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stallCount;
  int          mstall = 0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      16'h0003: return 16'h4444;
      default:  return a ^ 16'hA5C3;
    endcase
  endfunction

  assign memDataOut = memf(memAddress);

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .memAddress    (memAddress),
    .memWriteEnable(memWriteEnable),
    .memDataOut    (memDataOut),
    .instr         (instr),
    .instrPC       (instrPC),
    .instrValid    (instrValid),
    .instrReady    (rdy),
    .redirect      (redirect),
    .redirectPC    (rpc),
    .halt          (halt)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stallCount    (stallCount)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {word, pc} and a mode number.
  typedef struct {
    logic [15:0] w;
    logic [15:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [15:0] mpc = 16'h0000;
  int          mst = 0;  // 0 idle, 1 run, 2 halted

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mpc = 16'h0000;
      mst = 0;
`ifdef FETCH_STALL_CNT_EN
      mstall = 0;
`endif
    end else if (mst == 0) begin
      mst = halt ? 2 : 1;
    end else if (redirect) begin
      q.delete();
      mpc = rpc;
      mst = (halt || mst == 2) ? 2 : 1;
    end else begin
      bit pop, fetch;
      pop = (q.size() > 0) && rdy;
      fetch = (mst == 1) && !halt && (q.size() < 2 || pop);
`ifdef FETCH_STALL_CNT_EN
      if (mst == 1 && !halt && !fetch && mstall < 65535) mstall++;
`endif
      if (pop) void'(q.pop_front());
      if (fetch) begin
        ent_t e;
        e.w = memf(mpc);
        e.pc = mpc;
        q.push_back(e);
        mpc = mpc + 16'd1;
      end
      mst = halt ? 2 : 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_valid", 32'(instrValid), 32'(q.size() > 0));
      chk("m_addr", 32'(memAddress), 32'(mpc));
      chk("m_we", 32'(memWriteEnable), 32'd0);
      if (q.size() > 0) begin
        chk("m_instr", 32'(instr), 32'(q[0].w));
        chk("m_ipc", 32'(instrPC), 32'(q[0].pc));
      end
`ifdef FETCH_STALL_CNT_EN
      chk("m_stall", 32'(stallCount), 32'(mstall));
`endif
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  logic [15:0] t1w[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] t4p[3] = '{16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] t4w[3] = '{16'h5A3C, 16'h1111, 16'h2222};
  logic [23:0] rpat = 24'b1011_0011_1000_1101_0110_1110;

  initial begin
    nx();
    nx();
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_addr", 32'(memAddress), 32'h0000);
    chk("rst_we", 32'(memWriteEnable), 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall", 32'(stallCount), 32'd0);
`endif
    reset = 1'b0;

    // 1: streaming from reset
    nx();
    chk("t1_lat", 32'(instrValid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nx();
      chk("t1_valid", 32'(instrValid), 32'd1);
      chk("t1_instr", 32'(instr), 32'(t1w[i]));
      chk("t1_pc", 32'(instrPC), 32'(i));
    end

    // 2: decode not ready, FIFO fills
    reset = 1'b1;
    nx();
    reset = 1'b0;
    rdy = 1'b0;
    repeat (6) nx();
    chk("t2_valid", 32'(instrValid), 32'd1);
    chk("t2_instr", 32'(instr), 32'h1111);
    chk("t2_pc", 32'(instrPC), 32'h0000);
    chk("t2_addr", 32'(memAddress), 32'h0002);
`ifdef FETCH_STALL_CNT_EN
    chk("t2_stall", 32'(stallCount), 32'd3);
`endif

    // 3: redirect with full FIFO
    redirect = 1'b1;
    rpc = 16'h0040;
    nx();
    redirect = 1'b0;
    chk("t3_flush", 32'(instrValid), 32'd0);
    nx();
    chk("t3_valid", 32'(instrValid), 32'd1);
    chk("t3_instr", 32'(instr), 32'hA583);
    chk("t3_pc", 32'(instrPC), 32'h0040);

    // 4: redirect to top of address space, wrap
    redirect = 1'b1;
    rpc = 16'hFFFF;
    rdy = 1'b1;
    nx();
    redirect = 1'b0;
    chk("t4_flush", 32'(instrValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nx();
      chk("t4_valid", 32'(instrValid), 32'd1);
      chk("t4_pc", 32'(instrPC), 32'(t4p[i]));
      chk("t4_instr", 32'(instr), 32'(t4w[i]));
    end

    // 5: halt drains FIFO, then resumes
    rdy = 1'b0;
    nx();
    nx();
    chk("t5_full_pc", 32'(instrPC), 32'h0001);
    chk("t5_addr", 32'(memAddress), 32'h0003);
    halt = 1'b1;
    rdy = 1'b1;
    nx();
    chk("t5_drain_v", 32'(instrValid), 32'd1);
    chk("t5_drain_pc", 32'(instrPC), 32'h0002);
    nx();
    chk("t5_empty", 32'(instrValid), 32'd0);
    nx();
    chk("t5_held_v", 32'(instrValid), 32'd0);
    chk("t5_held_a", 32'(memAddress), 32'h0003);
    halt = 1'b0;
    nx();
    chk("t5_res_lat", 32'(instrValid), 32'd0);
    nx();
    chk("t5_res_v", 32'(instrValid), 32'd1);
    chk("t5_res_pc", 32'(instrPC), 32'h0003);
    chk("t5_res_in", 32'(instr), 32'h4444);

    // 6: asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(instrValid), 32'd0);
    chk("t6_addr", 32'(memAddress), 32'h0000);
`ifdef FETCH_STALL_CNT_EN
    chk("t6_stall", 32'(stallCount), 32'd0);
`endif
    nx();
    reset = 1'b0;

    // 7: redirect together with halt
    repeat (5) nx();
    redirect = 1'b1;
    rpc = 16'h0010;
    halt = 1'b1;
    nx();
    redirect = 1'b0;
    chk("t7_flush", 32'(instrValid), 32'd0);
    repeat (2) nx();
    chk("t7_hold_v", 32'(instrValid), 32'd0);
    chk("t7_hold_a", 32'(memAddress), 32'h0010);
    halt = 1'b0;
    repeat (2) nx();
    chk("t7_res_pc", 32'(instrPC), 32'h0010);
    chk("t7_res_in", 32'(instr), 32'hA5D3);

    // 8: irregular ready pattern with a mid-stream redirect
    for (int i = 0; i < 24; i++) begin
      rdy = rpat[i];
      redirect = (i == 12);
      rpc = 16'h0020;
      nx();
    end
    redirect = 1'b0;
    rdy = 1'b1;
    repeat (4) nx();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
